// File: rtl/brush_painter.sv
// brush_painter: takes a paint request carrying a one-hot colour and a brush
// centre, and stamps a BRUSH x BRUSH square of that colour into the frame
// buffer one pixel at a time over a valid/ready write port. Pixels that fall
// off the screen are skipped rather than written.
module brush_painter #(
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int BRUSH = 3,
   parameter int X_W   = 10,
   parameter int Y_W   = 9
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           paint_req,
   input  logic [X_W-1:0] x,
   input  logic [Y_W-1:0] y,
   input  logic [6:0]     color,
   output logic           busy,
   output logic           wr_valid,
   input  logic           wr_ready,
   output logic [X_W-1:0] wr_x,
   output logic [Y_W-1:0] wr_y,
   output logic [23:0]    wr_rgb,
   output logic           done,
   output logic           err
);

   localparam int         R    = (BRUSH - 1) / 2;
   localparam logic [3:0] LAST = 4'(BRUSH - 1);

   typedef enum logic [2:0] {IDLE, CHECK, STEP, WRITE, FINISH} state_t;

   state_t         state_reg;
   logic [X_W-1:0] x_reg;
   logic [Y_W-1:0] y_reg;
   logic [6:0]     color_reg;
   logic [23:0]    rgb_reg;
   logic [3:0]     dx_reg;
   logic [3:0]     dy_reg;

   // Two extra bits: one for the sign, one so x-R+dx never wraps.
   logic signed [X_W+1:0] px;
   logic signed [Y_W+1:0] py;
   logic                  in_bounds;
   logic                  last_pixel;
   logic                  color_ok;

   // Current pixel position relative to the latched centre, and its clip test.
   always_comb begin
      px = $signed((X_W+2)'(x_reg)) - $signed((X_W+2)'(R)) + $signed((X_W+2)'(dx_reg));
      py = $signed((Y_W+2)'(y_reg)) - $signed((Y_W+2)'(R)) + $signed((Y_W+2)'(dy_reg));
      in_bounds = (px >= 0) && (px < $signed((X_W+2)'(H_RES))) &&
                  (py >= 0) && (py < $signed((Y_W+2)'(V_RES)));
      last_pixel = (dx_reg == LAST) && (dy_reg == LAST);
      color_ok   = (color_reg != 7'd0) && ((color_reg & (color_reg - 7'd1)) == 7'd0);
   end

   // One-hot colour select to 24-bit {R,G,B}.
   function automatic logic [23:0] decode_rgb(input logic [6:0] c);
      logic [23:0] rgb;
      rgb = 24'h000000;
      if (c[6]) rgb = 24'hFFFFFF;
      if (c[5]) rgb = 24'h000000;
      if (c[4]) rgb = 24'hFF0000;
      if (c[3]) rgb = 24'h0000FF;
      if (c[2]) rgb = 24'hFFFF00;
      if (c[1]) rgb = 24'h00FF00;
      if (c[0]) rgb = 24'h800080;
      return rgb;
   endfunction

   // Stamp sequencer; all outputs are registered. done/busy change on the
   // transition into FINISH so that done is visible during the FINISH cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         busy      <= 1'b0;
         wr_valid  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         wr_x      <= '0;
         wr_y      <= '0;
         wr_rgb    <= '0;
         x_reg     <= '0;
         y_reg     <= '0;
         color_reg <= '0;
         rgb_reg   <= '0;
         dx_reg    <= '0;
         dy_reg    <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_reg)
            IDLE: begin
               // The err cycle counts as the tail of the rejected request,
               // so a request coinciding with it is dropped.
               if (paint_req && !err) begin
                  x_reg     <= x;
                  y_reg     <= y;
                  color_reg <= color;
                  busy      <= 1'b1;
                  state_reg <= CHECK;
               end
            end
            CHECK: begin
               if (!color_ok) begin
                  err       <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  rgb_reg   <= decode_rgb(color_reg);
                  dx_reg    <= '0;
                  dy_reg    <= '0;
                  state_reg <= STEP;
               end
            end
            STEP: begin
               if (in_bounds) begin
                  wr_x      <= px[X_W-1:0];
                  wr_y      <= py[Y_W-1:0];
                  wr_rgb    <= rgb_reg;
                  wr_valid  <= 1'b1;
                  state_reg <= WRITE;
               end else if (last_pixel) begin
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= FINISH;
               end else begin
                  if (dx_reg == LAST) begin
                     dx_reg <= '0;
                     dy_reg <= dy_reg + 4'd1;
                  end else begin
                     dx_reg <= dx_reg + 4'd1;
                  end
               end
            end
            WRITE: begin
               if (wr_ready) begin
                  wr_valid <= 1'b0;
                  if (last_pixel) begin
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     state_reg <= FINISH;
                  end else begin
                     if (dx_reg == LAST) begin
                        dx_reg <= '0;
                        dy_reg <= dy_reg + 4'd1;
                     end else begin
                        dx_reg <= dx_reg + 4'd1;
                     end
                     state_reg <= STEP;
                  end
               end
            end
            FINISH: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
               wr_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_brush_painter.sv
// Bench for brush_painter: a scoreboard of expected pixel writes is filled
// from a reference model when each request is issued and drained by a
// monitor on every write handshake.
module tb_brush_painter;

   localparam int H_RES = 640;
   localparam int V_RES = 480;
   localparam int BRUSH = 3;
   localparam int X_W   = 10;
   localparam int Y_W   = 9;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           paint_req = 1'b0;
   logic [X_W-1:0] x = '0;
   logic [Y_W-1:0] y = '0;
   logic [6:0]     color = '0;
   logic           busy;
   logic           wr_valid;
   logic           wr_ready = 1'b1;
   logic [X_W-1:0] wr_x;
   logic [Y_W-1:0] wr_y;
   logic [23:0]    wr_rgb;
   logic           done;
   logic           err;

   int checks = 0;
   int errors = 0;
   int hs_count = 0;
   int done_count = 0;
   int err_count = 0;

   typedef struct packed {
      logic [X_W-1:0] px;
      logic [Y_W-1:0] py;
      logic [23:0]    rgb;
   } pix_t;

   pix_t exp_q[$];

   brush_painter #(.H_RES(H_RES), .V_RES(V_RES), .BRUSH(BRUSH), .X_W(X_W), .Y_W(Y_W)) dut (
      .clk(clk), .reset(reset), .paint_req(paint_req), .x(x), .y(y), .color(color),
      .busy(busy), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
      .wr_rgb(wr_rgb), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] model_rgb(input logic [6:0] c);
      case (c)
         7'b1000000: return 24'hFFFFFF;
         7'b0100000: return 24'h000000;
         7'b0010000: return 24'hFF0000;
         7'b0001000: return 24'h0000FF;
         7'b0000100: return 24'hFFFF00;
         7'b0000010: return 24'h00FF00;
         7'b0000001: return 24'h800080;
         default:    return 24'h000000;
      endcase
   endfunction

   // Reference model: raster-order clipped square, pushed to the scoreboard.
   task automatic push_expected(input int cx, input int cy, input logic [6:0] c);
      int r;
      pix_t p;
      r = (BRUSH - 1) / 2;
      for (int dy = 0; dy < BRUSH; dy++) begin
         for (int dx = 0; dx < BRUSH; dx++) begin
            int px, py;
            px = cx - r + dx;
            py = cy - r + dy;
            if (px >= 0 && px < H_RES && py >= 0 && py < V_RES) begin
               p.px  = px[X_W-1:0];
               p.py  = py[Y_W-1:0];
               p.rgb = model_rgb(c);
               exp_q.push_back(p);
            end
         end
      end
   endtask

   // Monitor: every handshake is checked against the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (done) done_count++;
         if (err)  err_count++;
         if (wr_valid && wr_ready) begin
            hs_count++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected: got (%0d,%0d) %h, required no write", wr_x, wr_y, wr_rgb);
            end else begin
               pix_t e;
               e = exp_q.pop_front();
               if ({wr_x, wr_y, wr_rgb} !== {e.px, e.py, e.rgb}) begin
                  errors++;
                  $display("FAIL write_data: got (%0d,%0d) %h, required (%0d,%0d) %h",
                           wr_x, wr_y, wr_rgb, e.px, e.py, e.rgb);
               end else begin
                  $display("write (%0d,%0d) rgb=%h", wr_x, wr_y, wr_rgb);
               end
            end
         end
      end
   end

   task automatic issue(input int cx, input int cy, input logic [6:0] c);
      @(posedge clk); #1;
      paint_req = 1'b1;
      x = cx[X_W-1:0];
      y = cy[Y_W-1:0];
      color = c;
   endtask

   // Waits for done with a cycle budget, then checks scoreboard drained.
   task automatic wait_done(input string name, input int nwrites);
      int n;
      int hs0;
      hs0 = hs_count - 0;
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: got no done within 200 cycles, required done", name);
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || hs_count != nwrites) begin
         errors++;
         $display("FAIL %s_writes: got %0d handshakes (%0d left), required %0d", name, hs_count, exp_q.size(), nwrites);
      end
      $display("stamp %s: %0d writes", name, hs_count);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, wr_valid, done, err, wr_x, wr_y, wr_rgb} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b v=%b done=%b err=%b x=%0d y=%0d rgb=%h, required all zero",
                  busy, wr_valid, done, err, wr_x, wr_y, wr_rgb);
      end
      $display("reset checked");
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Cycle-exact timing of a fully on-screen stamp.
   task automatic test_center;
      hs_count = 0; done_count = 0;
      push_expected(100, 50, 7'b0010000);
      issue(100, 50, 7'b0010000);
      for (int cyc = 0; cyc <= 22; cyc++) begin
         @(negedge clk);
         checks++;
         if (busy !== (cyc >= 1 && cyc <= 19) || done !== (cyc == 20)) begin
            errors++;
            $display("FAIL center_timing: cycle %0d got busy=%b done=%b, required busy=%b done=%b",
                     cyc, busy, done, (cyc >= 1 && cyc <= 19), (cyc == 20));
         end
         @(posedge clk); #1;
         paint_req = 1'b0;
      end
      checks++;
      if (hs_count != 9 || exp_q.size() != 0 || done_count != 1) begin
         errors++;
         $display("FAIL center_writes: got %0d writes, %0d dones, required 9 writes, 1 done", hs_count, done_count);
      end
      $display("stamp center: %0d writes", hs_count);
   endtask

   task automatic test_corner(input string name, input int cx, input int cy, input logic [6:0] c);
      hs_count = 0;
      push_expected(cx, cy, c);
      issue(cx, cy, c);
      @(posedge clk); #1;
      paint_req = 1'b0;
      wait_done(name, 4);
   endtask

   task automatic test_bad_color(input logic [6:0] c);
      hs_count = 0; done_count = 0; err_count = 0;
      issue(100, 50, c);
      for (int cyc = 0; cyc <= 5; cyc++) begin
         @(negedge clk);
         checks++;
         if (err !== (cyc == 2) || busy !== (cyc == 1) || wr_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL bad_color_%b: cycle %0d got err=%b busy=%b v=%b done=%b, required err=%b busy=%b v=0 done=0",
                     c, cyc, err, busy, wr_valid, done, (cyc == 2), (cyc == 1));
         end
         @(posedge clk); #1;
         paint_req = 1'b0;
      end
      checks++;
      if (err_count != 1 || hs_count != 0 || done_count != 0) begin
         errors++;
         $display("FAIL bad_color_count: got err=%0d writes=%0d done=%0d, required 1/0/0", err_count, hs_count, done_count);
      end
      $display("reject color %b: err pulses=%0d", c, err_count);
   endtask

   // Stall the second pixel; also throw in an ignored request while busy.
   task automatic test_backpressure;
      hs_count = 0;
      push_expected(200, 100, 7'b0001000);
      issue(200, 100, 7'b0001000);
      for (int cyc = 0; cyc <= 10; cyc++) begin
         @(negedge clk);
         if (cyc >= 5 && cyc <= 9) begin
            checks++;
            if (wr_valid !== 1'b1 || wr_x !== 10'd200 || wr_y !== 9'd99 || wr_rgb !== 24'h0000FF) begin
               errors++;
               $display("FAIL stall_hold: cycle %0d got v=%b (%0d,%0d) %h, required v=1 (200,99) 0000ff",
                        cyc, wr_valid, wr_x, wr_y, wr_rgb);
            end
         end
         @(posedge clk); #1;
         paint_req = (cyc + 1 == 6);
         if (cyc + 1 == 6) begin x = 10'd5; y = 9'd5; color = 7'b0000010; end
         wr_ready = !((cyc + 1) >= 5 && (cyc + 1) <= 9);
      end
      paint_req = 1'b0;
      wr_ready = 1'b1;
      wait_done("backpressure", 9);
   endtask

   // Reset while pixel index 4 is waiting in WRITE, then a clean stamp.
   task automatic test_reset_mid;
      pix_t p;
      hs_count = 0; done_count = 0; err_count = 0;
      push_expected(300, 200, 7'b0000100);
      issue(300, 200, 7'b0000100);
      for (int cyc = 0; cyc < 11; cyc++) begin
         @(posedge clk); #1;
         paint_req = 1'b0;
         if (cyc + 1 == 11) begin wr_ready = 1'b0; reset = 1'b1; end
      end
      @(negedge clk);
      checks++;
      if (wr_valid !== 1'b1 || hs_count != 4) begin
         errors++;
         $display("FAIL reset_mid_setup: got v=%b writes=%0d, required v=1 writes=4", wr_valid, hs_count);
      end
      @(negedge clk);
      checks++;
      if (wr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got v=%b busy=%b done=%b err=%b, required all 0", wr_valid, busy, done, err);
      end
      while (exp_q.size() > 0) p = exp_q.pop_front();
      @(posedge clk); #1;
      reset = 1'b0;
      wr_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (done_count != 0 || err_count != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_quiet: got done=%0d err=%0d busy=%b, required 0/0/0", done_count, err_count, busy);
      end
      $display("reset mid-stamp abandoned after %0d writes", hs_count);
      hs_count = 0;
      push_expected(50, 60, 7'b0100000);
      issue(50, 60, 7'b0100000);
      @(posedge clk); #1;
      paint_req = 1'b0;
      wait_done("after_reset", 9);
   endtask

   task automatic test_offscreen;
      hs_count = 0; err_count = 0;
      issue(1000, 500, 7'b0000010);
      @(posedge clk); #1;
      paint_req = 1'b0;
      wait_done("offscreen", 0);
      checks++;
      if (err_count != 0) begin
         errors++;
         $display("FAIL offscreen_err: got %0d err pulses, required 0", err_count);
      end
   endtask

   initial begin
      test_reset();
      test_center();
      test_corner("top_left", 0, 0, 7'b0000001);
      test_corner("bottom_right", 639, 479, 7'b1000000);
      test_bad_color(7'b0000000);
      test_bad_color(7'b0110000);
      test_backpressure();
      test_offscreen();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
